// File: rtl/ball_motion_ctrl.sv
// ----------------------------------------------------------------------------
// ball_motion_ctrl
//
// Produces registered ball coordinates for the VGA drawing logic. Horizontal
// motion is free-running (wrap or bounce). Vertical motion follows the
// debounced left/right buttons, and holding a button steps faster. A
// synchronous load strobe places y directly. All motion is paced by a
// programmable tick divider that only runs while the block is enabled.
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   reset     in   asynchronous, active-high reset
//   en        in   motion enable; 0 freezes motion
//   left      in   move up (decrement y), sampled on ticks only
//   right     in   move down (increment y), sampled on ticks only
//   x_mode    in   0 = wrap, 1 = bounce
//   load      in   one-cycle strobe, loads clamp(y_load) into y_ball
//   y_load    in   [Y_W-1:0] y value for load
//   x_ball    out  [X_W-1:0] current x
//   y_ball    out  [Y_W-1:0] current y
//   x_dir     out  horizontal direction, 1 = increasing
//   x_edge    out  one-cycle pulse on a wrap or bounce event
//   at_y_min  out  y_ball == Y_MIN
//   at_y_max  out  y_ball == Y_MAX
// ----------------------------------------------------------------------------
module ball_motion_ctrl #(
   parameter int X_W         = 9,
   parameter int Y_W         = 10,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 479,
   parameter int X_INIT      = 0,
   parameter int Y_MIN       = 84,
   parameter int Y_MAX       = 596,
   parameter int Y_INIT      = 340,
   parameter int X_STEP      = 1,
   parameter int Y_STEP      = 1,
   parameter int Y_STEP_FAST = 4,
   parameter int HOLD_TICKS  = 8,
   parameter int TICK_DIV    = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic           left,
   input  logic           right,
   input  logic           x_mode,
   input  logic           load,
   input  logic [Y_W-1:0] y_load,
   output logic [X_W-1:0] x_ball,
   output logic [Y_W-1:0] y_ball,
   output logic           x_dir,
   output logic           x_edge,
   output logic           at_y_min,
   output logic           at_y_max
);

   // -------------------------------------------------------------------------
   // Derived widths and sized constants
   // -------------------------------------------------------------------------
   localparam int DIV_W  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)       : 1;
   localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

   // Arithmetic is done one bit wider than the coordinate so that the
   // saturating compares can never wrap around.
   localparam logic [Y_W:0] Y_MIN_E       = (Y_W+1)'(Y_MIN);
   localparam logic [Y_W:0] Y_MAX_E       = (Y_W+1)'(Y_MAX);
   localparam logic [Y_W:0] Y_STEP_E      = (Y_W+1)'(Y_STEP);
   localparam logic [Y_W:0] Y_STEP_FAST_E = (Y_W+1)'(Y_STEP_FAST);
   localparam logic [X_W:0] X_MIN_E       = (X_W+1)'(X_MIN);
   localparam logic [X_W:0] X_MAX_E       = (X_W+1)'(X_MAX);
   localparam logic [X_W:0] X_STEP_E      = (X_W+1)'(X_STEP);

   localparam logic [Y_W-1:0] Y_MIN_V  = Y_W'(Y_MIN);
   localparam logic [Y_W-1:0] Y_MAX_V  = Y_W'(Y_MAX);
   localparam logic [Y_W-1:0] Y_INIT_V = Y_W'(Y_INIT);
   localparam logic [X_W-1:0] X_MIN_V  = X_W'(X_MIN);
   localparam logic [X_W-1:0] X_MAX_V  = X_W'(X_MAX);
   localparam logic [X_W-1:0] X_INIT_V = X_W'(X_INIT);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Direction of the most recent vertical tick, remembered so that a held
   // button can be told apart from a fresh press.
   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } vdir_t;

   state_t             state;
   state_t             state_next;
   logic [DIV_W-1:0]   div_cnt;
   logic               tick;

   vdir_t              last_dir;
   vdir_t              tick_dir;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [HOLD_W-1:0]  hold_new;
   logic [Y_W:0]       y_ext;
   logic [Y_W:0]       y_step;
   logic [Y_W:0]       y_load_ext;
   logic [Y_W-1:0]     y_move;
   logic [Y_W-1:0]     y_clamp;

   logic [X_W:0]       x_ext;
   logic [X_W:0]       x_inc;
   logic [X_W-1:0]     x_next;
   logic               dir_next;
   logic               edge_next;

   // -------------------------------------------------------------------------
   // Run/idle FSM
   // -------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case/if tree leaves it unassigned (which infers a latch).
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (en)  state_next = RUN;
         RUN:     if (!en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Tick divider: zero while idle and on the first RUN cycle, so the first
   // tick lands TICK_DIV cycles into a run.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (state != RUN || state_next != RUN) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (state == RUN) && (div_cnt == DIV_LAST);

   // -------------------------------------------------------------------------
   // Vertical path: direction decode, hold counter, saturating step, load clamp
   // -------------------------------------------------------------------------
   always_comb begin
      tick_dir = DIR_NONE;
      if (left && !right) begin
         tick_dir = DIR_UP;
      end else if (right && !left) begin
         tick_dir = DIR_DOWN;
      end

      // A held direction keeps counting; the first tick in a new direction
      // (or after a release or load, which clear hold_cnt) counts as 1.
      hold_new = '0;
      if (tick_dir != DIR_NONE) begin
         if (tick_dir == last_dir && hold_cnt != '0) begin
            hold_new = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1;
         end else begin
            hold_new = HOLD_W'(1);
         end
      end

      // The step for this tick already reflects this tick's hold count.
      y_step = (hold_new >= HOLD_MAX) ? Y_STEP_FAST_E : Y_STEP_E;
      y_ext  = {1'b0, y_ball};

      y_move = y_ball;
      case (tick_dir)
         DIR_UP: begin
            if (y_ext < Y_MIN_E + y_step) y_move = Y_MIN_V;
            else                          y_move = Y_W'(y_ext - y_step);
         end
         DIR_DOWN: begin
            if (y_ext + y_step > Y_MAX_E) y_move = Y_MAX_V;
            else                          y_move = Y_W'(y_ext + y_step);
         end
         default: y_move = y_ball;
      endcase

      y_load_ext = {1'b0, y_load};
      if (y_load_ext < Y_MIN_E) begin
         y_clamp = Y_MIN_V;
      end else if (y_load_ext > Y_MAX_E) begin
         y_clamp = Y_MAX_V;
      end else begin
         y_clamp = y_load;
      end
   end

   // Load outranks the tick and is honoured in any FSM state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_ball   <= Y_INIT_V;
         hold_cnt <= '0;
         last_dir <= DIR_NONE;
      end else if (load) begin
         y_ball   <= y_clamp;
         hold_cnt <= '0;
         last_dir <= DIR_NONE;
      end else if (tick) begin
         y_ball   <= y_move;
         hold_cnt <= hold_new;
         last_dir <= tick_dir;
      end
   end

   assign at_y_min = (y_ball == Y_MIN_V);
   assign at_y_max = (y_ball == Y_MAX_V);

   // -------------------------------------------------------------------------
   // Horizontal path. x_mode is read on the tick itself, so a mode change
   // takes effect at the next tick; wrap mode always drives x_dir back to 1.
   // -------------------------------------------------------------------------
   always_comb begin
      x_ext     = {1'b0, x_ball};
      x_inc     = x_ext + X_STEP_E;
      x_next    = x_ball;
      dir_next  = x_dir;
      edge_next = 1'b0;

      if (!x_mode) begin
         dir_next = 1'b1;
         if (x_inc > X_MAX_E) begin
            x_next    = X_MIN_V;
            edge_next = 1'b1;
         end else begin
            x_next = X_W'(x_inc);
         end
      end else if (x_dir) begin
         if (x_inc >= X_MAX_E) begin
            x_next    = X_MAX_V;
            dir_next  = 1'b0;
            edge_next = 1'b1;
         end else begin
            x_next = X_W'(x_inc);
         end
      end else begin
         if (x_ext <= X_MIN_E + X_STEP_E) begin
            x_next    = X_MIN_V;
            dir_next  = 1'b1;
            edge_next = 1'b1;
         end else begin
            x_next = X_W'(x_ext - X_STEP_E);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_ball <= X_INIT_V;
         x_dir  <= 1'b1;
         x_edge <= 1'b0;
      end else begin
         // Pulse lasts exactly the cycle that shows the updated x_ball.
         x_edge <= tick && edge_next;
         if (tick) begin
            x_ball <= x_next;
            x_dir  <= dir_next;
         end
      end
   end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ball_motion_ctrl
//
// Directed bench for ball_motion_ctrl with default parameters (TICK_DIV=4).
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// After the first tick the bench stays aligned to update edges: from an
// aligned point, the next position update is visible 4 edges later.
// ----------------------------------------------------------------------------
module tb_ball_motion_ctrl;

   logic       clk;
   logic       reset;
   logic       en;
   logic       left;
   logic       right;
   logic       x_mode;
   logic       load;
   logic [9:0] y_load;
   logic [8:0] x_ball;
   logic [9:0] y_ball;
   logic       x_dir;
   logic       x_edge;
   logic       at_y_min;
   logic       at_y_max;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_x   = 0;
   bit exp_dir = 1'b1;

   ball_motion_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .left     (left),
      .right    (right),
      .x_mode   (x_mode),
      .load     (load),
      .y_load   (y_load),
      .x_ball   (x_ball),
      .y_ball   (y_ball),
      .x_dir    (x_dir),
      .x_edge   (x_edge),
      .at_y_min (at_y_min),
      .at_y_max (at_y_max)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One tick period with no boundary event on x.
   task automatic tick_step();
      adv(4);
      exp_x = exp_dir ? exp_x + 1 : exp_x - 1;
      check("x_tick", x_ball, exp_x);
      check("x_edge_quiet", x_edge, 0);
   endtask

   // Load strobe right after an update, then finish the tick period (buttons
   // released, so y must hold through that tick).
   task automatic do_load(input int val, input int exp);
      load   = 1'b1;
      y_load = 10'(val);
      adv(1);
      check("load_y", y_ball, exp);
      load = 1'b0;
      adv(3);
      exp_x = exp_x + 1;
      check("load_x", x_ball, exp_x);
      check("load_y_hold", y_ball, exp);
   endtask

   initial begin
      reset  = 1'b1;
      en     = 1'b0;
      left   = 1'b0;
      right  = 1'b0;
      x_mode = 1'b0;
      load   = 1'b0;
      y_load = '0;

      // Reset state
      adv(2);
      check("rst_x", x_ball, 0);
      check("rst_y", y_ball, 340);
      check("rst_dir", x_dir, 1);
      check("rst_edge", x_edge, 0);
      check("rst_ymin", at_y_min, 0);
      check("rst_ymax", at_y_max, 0);
      reset = 1'b0;
      adv(3);
      check("idle_x", x_ball, 0);
      check("idle_y", y_ball, 340);

      // First tick latency: RUN starts at the next edge, update 4 edges later
      en = 1'b1;
      adv(4);
      check("first_tick_early", x_ball, 0);
      adv(1);
      exp_x = 1;
      check("first_tick", x_ball, 1);
      check("first_tick_y", y_ball, 340);

      // Acceleration: +1 for ticks 1-7, +4 from tick 8
      right = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick_step();
         check("accel_y", y_ball, (i <= 7) ? 340 + i : 347 + 4 * (i - 7));
      end
      right = 1'b0;
      tick_step();
      check("release_y", y_ball, 367);
      right = 1'b1;
      tick_step();
      check("reaccel_y", y_ball, 368);
      right = 1'b0;

      // Clamp at Y_MIN
      do_load(86, 86);
      left = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick_step();
         check("clamp_min_y", y_ball, (i == 1) ? 85 : 84);
         check("at_y_min", at_y_min, (i >= 2) ? 1 : 0);
      end
      left = 1'b0;

      // Clamp at Y_MAX
      do_load(594, 594);
      right = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick_step();
         check("clamp_max_y", y_ball, (i == 1) ? 595 : 596);
         check("at_y_max", at_y_max, (i >= 2) ? 1 : 0);
      end
      right = 1'b0;

      // Load priority over a tick, with hold count cleared by the load
      do_load(340, 340);
      right = 1'b1;
      for (int i = 1; i <= 8; i++) tick_step();
      check("prio_fast_y", y_ball, 351);
      adv(3);
      load   = 1'b1;
      y_load = 10'd10;
      adv(1);
      load  = 1'b0;
      exp_x = exp_x + 1;
      check("prio_load_x", x_ball, exp_x);
      check("prio_load_low", y_ball, 84);
      tick_step();
      check("prio_hold_cleared", y_ball, 85);
      adv(3);
      load   = 1'b1;
      y_load = 10'd700;
      adv(1);
      load  = 1'b0;
      exp_x = exp_x + 1;
      check("prio_load_high", y_ball, 596);
      left = 1'b1;
      tick_step();
      check("both_buttons_y", y_ball, 596);
      right = 1'b0;
      tick_step();
      check("left_after_both", y_ball, 595);
      left = 1'b0;

      // Enable dropped mid-count for 6 cycles, load while idle
      adv(1);
      en    = 1'b0;
      right = 1'b1;
      for (int i = 0; i < 6; i++) begin
         adv(1);
         check("en_low_x", x_ball, exp_x);
         check("en_low_y", y_ball, (i == 0) ? 595 : 450);
         load   = (i == 0);
         y_load = 10'd450;
      end
      en = 1'b1;
      adv(4);
      check("reen_early_x", x_ball, exp_x);
      adv(1);
      exp_x = exp_x + 1;
      check("reen_x", x_ball, exp_x);
      check("reen_y", y_ball, 451);
      right = 1'b0;

      // Wrap mode around X_MAX
      while (exp_x < 478) tick_step();
      adv(4);
      check("wrap_479", x_ball, 479);
      check("wrap_479_edge", x_edge, 0);
      adv(4);
      check("wrap_0", x_ball, 0);
      check("wrap_edge", x_edge, 1);
      adv(1);
      check("wrap_edge_drop", x_edge, 0);
      adv(3);
      exp_x = 1;
      check("wrap_1", x_ball, 1);

      // Bounce mode: top, descent, bottom
      x_mode = 1'b1;
      while (exp_x < 478) tick_step();
      adv(4);
      check("bounce_top_x", x_ball, 479);
      check("bounce_top_dir", x_dir, 0);
      check("bounce_top_edge", x_edge, 1);
      adv(1);
      check("bounce_edge_drop", x_edge, 0);
      adv(3);
      check("bounce_478", x_ball, 478);
      check("bounce_478_dir", x_dir, 0);
      exp_x   = 478;
      exp_dir = 1'b0;
      while (exp_x > 1) tick_step();
      adv(4);
      check("bounce_bot_x", x_ball, 0);
      check("bounce_bot_dir", x_dir, 1);
      check("bounce_bot_edge", x_edge, 1);
      adv(4);
      check("bounce_up_1", x_ball, 1);
      check("bounce_up_edge", x_edge, 0);
      exp_x   = 1;
      exp_dir = 1'b1;

      // Switch to wrap while decreasing: direction flips to 1 at that tick
      while (exp_x < 478) tick_step();
      adv(4);
      check("top2_x", x_ball, 479);
      adv(4);
      check("top2_down", x_ball, 478);
      check("top2_dir", x_dir, 0);
      x_mode = 1'b0;
      adv(4);
      check("mode_sw_x", x_ball, 479);
      check("mode_sw_dir", x_dir, 1);
      check("mode_sw_edge", x_edge, 0);
      adv(4);
      check("mode_sw_wrap", x_ball, 0);
      check("mode_sw_wrap_edge", x_edge, 1);
      exp_x = 0;

      // Asynchronous reset mid-run
      do_load(500, 500);
      adv(2);
      #3;
      reset = 1'b1;
      #1;
      check("async_rst_y", y_ball, 340);
      check("async_rst_x", x_ball, 0);
      check("async_rst_dir", x_dir, 1);
      check("async_rst_edge", x_edge, 0);
      en = 1'b0;
      adv(2);
      reset = 1'b0;
      adv(8);
      check("post_rst_x", x_ball, 0);
      check("post_rst_y", y_ball, 340);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Parametrised successor to the single-speed ball position updater. Produces registered ball coordinates for the display path from left/right buttons and a free-running horizontal motion engine. Adds four features: a programmable update rate, hold-to-accelerate vertical steps, wrap or bounce horizontal mode, and a synchronous position load. Sits between the button synchroniser/debouncer and the VGA drawing logic.

## Interface
- X_W, 9, width of x coordinate
- Y_W, 10, width of y coordinate
- X_MIN / X_MAX / X_INIT, 0 / 479 / 0, horizontal bounds and reset value
- Y_MIN / Y_MAX / Y_INIT, 84 / 596 / 340, vertical bounds and reset value
- X_STEP, 1, horizontal advance per tick
- Y_STEP, 1, vertical step per tick before acceleration
- Y_STEP_FAST, 4, vertical step per tick after acceleration
- HOLD_TICKS, 8, consecutive same-direction ticks before Y_STEP_FAST applies
- TICK_DIV, 4, clk cycles per motion tick (>=1)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces reset state immediately
- en  in  1  motion enable; 0 freezes motion
- left  in  1  move up (decrement y), synchronous, debounced upstream
- right  in  1  move down (increment y)
- x_mode  in  1  0 = wrap, 1 = bounce
- load  in  1  one-cycle strobe to load y
- y_load  in  Y_W  y value for load
- x_ball  out  X_W  current x
- y_ball  out  Y_W  current y
- x_dir  out  1  horizontal direction, 1 = increasing
- x_edge  out  1  one-cycle pulse on a wrap or bounce event
- at_y_min / at_y_max  out  1  y_ball == Y_MIN / Y_MAX

## Operation
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN on en=1. RUN -> IDLE on en=0.
  - In IDLE, tick counter held at 0 and no motion occurs.
  - The reset state is IDLE.
- Tick generation: in RUN, div_cnt counts 0..TICK_DIV-1 and wraps. tick = RUN && div_cnt==TICK_DIV-1.
- Vertical update on tick:
  - left-only: y <= max(y - step, Y_MIN).
  - right-only: y <= min(y + step, Y_MAX).
  - Both or neither: y holds and hold_cnt clears.
  - Saturating arithmetic uses Y_W+1 bits, so no underflow or overflow.
- Acceleration:
  - hold_cnt increments on each tick that has the same direction as the previous tick. It saturates at HOLD_TICKS.
  - A direction change or release resets hold_cnt to 0. The first tick in a new direction counts as 1.
  - step = Y_STEP while hold_cnt < HOLD_TICKS, otherwise Y_STEP_FAST.
- Horizontal update on tick:
  - Wrap mode (x_dir forced to 1): if x + X_STEP > X_MAX, then x <= X_MIN and x_edge=1. Otherwise x <= x + X_STEP.
  - Bounce, increasing: if x + X_STEP >= X_MAX, then x <= X_MAX, x_dir <= 0, x_edge=1.
  - Bounce, decreasing: if x <= X_MIN + X_STEP, then x <= X_MIN, x_dir <= 1, x_edge=1.
  - Otherwise in bounce mode, x moves by X_STEP in the current direction.
- Changing x_mode mid-run takes effect at the next tick. Switching to wrap sets x_dir <= 1 at that tick.
- load:
  - Highest priority for y, and works in any state.
  - y <= clamp(y_load, Y_MIN, Y_MAX) and hold_cnt <= 0.
  - When load and tick coincide, load wins for y; x still updates.
- at_y_min and at_y_max are combinational compares of the registered y.

## Timing
- Reset values: x_ball=X_INIT, y_ball=Y_INIT, x_dir=1, x_edge=0, div_cnt=0, hold_cnt=0, state=IDLE.
- Reset mid-operation takes effect asynchronously. Outputs return to reset values with no tick pending.
- First tick arrives TICK_DIV cycles after the first RUN cycle. With TICK_DIV=1, every RUN cycle is a tick.
- Position outputs change on the clk edge that samples tick=1, giving one-cycle latency.
- Buttons are sampled only on tick cycles. Presses shorter than a tick period between ticks are ignored.
- x_edge is high exactly one cycle, coincident with the updated x_ball.
- load is visible on y_ball the cycle after the strobe.

## Test plan
- Reset: assert reset mid-run with y=500 -> same cycle y_ball=340, x_ball=0, x_dir=1, x_edge=0; no motion while en=0.
- Y clamp: y=86, hold left for 10 ticks -> 85, 84, 84...; at_y_min=1 from the second tick; y never below 84. Mirror test at 594 with right -> 596.
- Acceleration: from y=340, hold right for 12 ticks -> +1 for ticks 1-7, +4 from tick 8 (y=347, 351, ...); release for one tick, then right again -> back to +1.
- Wrap vs bounce: x=478, X_STEP=1, wrap -> 479, then 0 with x_edge pulse. Bounce from 478 -> 479 with x_dir=0 and x_edge, then 478. At 1 decreasing -> 0, x_dir=1.
- Load/priority: load y_load=700 on a tick with right held -> y_ball=596, hold_cnt=0; y_load=10 -> 84; left+right together -> y unchanged.
- Enable/rate: TICK_DIV=4, toggle en low for 6 cycles mid-count -> no updates while low; first update 4 cycles after en returns high.
